// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder: register block
// base/offsets, the register-select decode and the byte-lane merge used by RAM and registers.
package data_sram_resp_pkg;

  localparam logic [31:0] CONF_BASE_DEF = 32'hBFAF_0000;
  localparam logic [31:0] SIMU_FLAG_DEF = 32'hFFFF_FFFF;

  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] NUM_OFF    = 16'hF010;
  localparam logic [15:0] SWITCH_OFF = 16'hF020;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;
  localparam logic [15:0] SIMU_OFF   = 16'hFFF0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH,
    SEL_TIMER,
    SEL_SIMU
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [15:0] offset);
    reg_sel_e sel;
    case (offset)
      LED_OFF:    sel = SEL_LED;
      NUM_OFF:    sel = SEL_NUM;
      SWITCH_OFF: sel = SEL_SWITCH;
      TIMER_OFF:  sel = SEL_TIMER;
      SIMU_OFF:   sel = SEL_SIMU;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Enabled lanes take the new byte, disabled lanes keep the old one.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bus between the CPU MEM stage (master) and the responder (slave).
interface data_sram_resp_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_resp_sram_bank.sv
// Single-port, read-first, byte-writable DEPTH x 32 word RAM with a registered read port.
module sram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [DEPTH];

  // Writes are suppressed while reset is asserted; contents themselves are never cleared.
  always_ff @(posedge clk) begin
    if (en && !reset && (wen != 4'b0000)) begin
      mem[idx] <= byte_merge(mem[idx], wdata, wen);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= mem[idx];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: local word RAM plus LED/NUM/SWITCH/TIMER/SIMU_FLAG registers.
// Define DSRAM_TIMER_EN to build the free-running TIMER register at offset E000.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH     = 65536,
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
  parameter logic [31:0] SIMU_FLAG = SIMU_FLAG_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  data_sram_resp_if.slave         data_sram,
  output logic [15:0]             led,
  output logic [31:0]             num_data,
  input  logic [7:0]              switch
);

  logic        conf_hit;
  logic [15:0] offset;
  reg_sel_e    reg_sel;
  logic        reg_write;
  logic        ram_en;
  logic [31:0] ram_q;
  logic [31:0] reg_rd;
  logic [31:0] reg_q;
  logic        sel_ram;
  logic [31:0] timer_rd;

  assign conf_hit  = (data_sram.addr[31:16] == CONF_BASE[31:16]);
  assign offset    = data_sram.addr[15:0];
  assign reg_sel   = decode_offset(offset);
  assign reg_write = data_sram.en && conf_hit && (data_sram.wen != 4'b0000);
  assign ram_en    = data_sram.en && !conf_hit;

  sram_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sram_bank (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .wen   (data_sram.wen),
    .idx   (data_sram.addr[ADDR_W+1:2]),
    .wdata (data_sram.wdata),
    .q     (ram_q)
  );

`ifdef DSRAM_TIMER_EN
  logic [31:0] timer;

  // A same-cycle write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (reg_write && (reg_sel == SEL_TIMER)) begin
      timer <= byte_merge(timer, data_sram.wdata, data_sram.wen);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  assign timer_rd = timer;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    reg_rd = '0;
    case (reg_sel)
      SEL_LED:    reg_rd = {16'h0000, led};
      SEL_NUM:    reg_rd = num_data;
      SEL_SWITCH: reg_rd = {24'h000000, switch};
      SEL_TIMER:  reg_rd = timer_rd;
      SEL_SIMU:   reg_rd = SIMU_FLAG;
      default:    reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led      <= '0;
      num_data <= '0;
    end else if (reg_write) begin
      if (reg_sel == SEL_LED) begin
        if (data_sram.wen[0]) led[7:0]  <= data_sram.wdata[7:0];
        if (data_sram.wen[1]) led[15:8] <= data_sram.wdata[15:8];
      end
      if (reg_sel == SEL_NUM) begin
        num_data <= byte_merge(num_data, data_sram.wdata, data_sram.wen);
      end
    end
  end

  // Register reads share the RAM's one-cycle latency; sel_ram steers the final mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q   <= '0;
      sel_ram <= 1'b0;
    end else if (data_sram.en) begin
      reg_q   <= reg_rd;
      sel_ram <= !conf_hit;
    end
  end

  assign data_sram.rdata = sel_ram ? ram_q : reg_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: directed test-plan sequence followed by random traffic.
module tb_data_sram_resp;

  typedef struct {
    logic [31:0] v;
    bit          known;
  } exp_t;

`ifdef DSRAM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch_in;

  data_sram_resp_if bus ();

  data_sram_resp dut (
    .clk       (clk),
    .reset     (reset),
    .data_sram (bus.slave),
    .led       (led),
    .num_data  (num_data),
    .switch    (switch_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t        sb[$];
  logic [31:0] mdl_mem [int];
  logic [15:0] m_led   = '0;
  logic [31:0] m_num   = '0;
  logic [31:0] m_timer = '0;

  bit          pend     = 1'b0;
  bit          rst_seen = 1'b0;
  bit          started  = 1'b0;
  logic [31:0] last_v   = '0;
  bit          last_k   = 1'b0;

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus and advances the reference model across the next edge.
  task automatic apply_stimulus(input bit rst, input bit en, input logic [3:0] wen,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [7:0] sw);
    exp_t        e;
    int          idx;
    logic [15:0] off;
    bit          conf;
    logic [31:0] nxt_timer;
    @(negedge clk);
    #1;
    reset     = rst;
    bus.en    = en;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
    switch_in = sw;
    conf      = (addr[31:16] == 16'hBFAF);
    off       = addr[15:0];
    idx       = int'(addr[17:2]);
    nxt_timer = m_timer + 32'd1;
    if (rst) begin
      m_led     = '0;
      m_num     = '0;
      nxt_timer = '0;
    end else if (en) begin
      e.known = 1'b1;
      e.v     = '0;
      if (conf) begin
        if (off == 16'hF000)                  e.v = {16'h0, m_led};
        else if (off == 16'hF010)             e.v = m_num;
        else if (off == 16'hF020)             e.v = {24'h0, sw};
        else if (off == 16'hE000 && TIMER_EN) e.v = m_timer;
        else if (off == 16'hFFF0)             e.v = 32'hFFFF_FFFF;
        if (wen != 4'b0000) begin
          if (off == 16'hF000) begin
            if (wen[0]) m_led[7:0]  = wdata[7:0];
            if (wen[1]) m_led[15:8] = wdata[15:8];
          end
          if (off == 16'hF010) m_num = lane_merge(m_num, wdata, wen);
          if (off == 16'hE000 && TIMER_EN) nxt_timer = lane_merge(m_timer, wdata, wen);
        end
      end else begin
        if (mdl_mem.exists(idx)) e.v = mdl_mem[idx];
        else e.known = 1'b0;
        if (e.known && wen != 4'b0000) mdl_mem[idx] = lane_merge(e.v, wdata, wen);
        else if (!e.known && wen == 4'hF) mdl_mem[idx] = wdata;
      end
      sb.push_back(e);
    end
    m_timer = TIMER_EN ? nxt_timer : 32'h0;
  endtask

  always @(posedge clk) begin
    pend     <= bus.en && !reset;
    rst_seen <= reset;
  end

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      started = 1'b1;
      last_v  = '0;
      last_k  = 1'b1;
      check_output("rdata_reset", bus.rdata, 32'h0);
    end else if (pend) begin
      if (sb.size() == 0) begin
        check_output("sb_underflow", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        last_k = e.known;
        last_v = e.v;
        if (e.known) check_output("rdata", bus.rdata, e.v);
      end
    end else if (last_k) begin
      check_output("rdata_hold", bus.rdata, last_v);
    end
    if (started) begin
      check_output("led", {16'h0, led}, {16'h0, m_led});
      check_output("num_data", num_data, m_num);
    end
  end

  localparam logic [31:0] REG = 32'hBFAF_0000;

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic [15:0] offs [7];
    logic [15:0] his  [3];
    int          kind;
    offs = '{16'hF000, 16'hF010, 16'hF020, 16'hE000, 16'hFFF0, 16'hF100, 16'hF004};
    his  = '{16'h0000, 16'h0004, 16'h00FC};
    reset = 1'b1; bus.en = 1'b0; bus.wen = '0; bus.addr = '0; bus.wdata = '0; switch_in = '0;

    apply_stimulus(1, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(1, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'hF, 32'h0000_0010, 32'h1122_3344, 8'h00);
    apply_stimulus(0, 1, 4'h0, 32'h0000_0010, 32'h0, 8'h00);
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 8'h00);
    apply_stimulus(0, 1, 4'h0, 32'h0000_0010, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'hF, REG | 32'hF000, 32'h0000_1234, 8'h00);
    apply_stimulus(0, 1, 4'h0, REG | 32'hF020, 32'h0, 8'h5A);
    apply_stimulus(0, 1, 4'h0, REG | 32'hFFF0, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'h0, REG | 32'hF100, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'h0, REG | 32'hE000, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'hF, REG | 32'hE000, 32'hFFFF_FFFE, 8'h00);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 4'h0, REG | 32'hE000, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'hF, 32'h0004_0000, 32'hCAFE_BABE, 8'h00);
    apply_stimulus(0, 1, 4'h0, 32'h0000_0000, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'hF, REG | 32'hF010, 32'h0000_0005, 8'h00);
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00);
    apply_stimulus(0, 1, 4'h0, 32'h0000_0010, 32'h0, 8'h00);
    apply_stimulus(0, 1, 4'h0, REG | 32'hE000, 32'h0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      w    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if (kind <= 4) begin
        a = {his[$urandom_range(0, 2)], 16'h0} | (32'($urandom_range(4, 11)) << 2)
            | 32'($urandom_range(0, 3));
      end else begin
        a = REG | {16'h0, offs[$urandom_range(0, 6)]};
      end
      apply_stimulus($urandom_range(0, 59) == 0, kind != 9, w, a, $urandom, 8'($urandom));
    end

    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    @(negedge clk);
    #2;
    check_output("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
Responder for the CPU core's data SRAM interface (en/wen/addr/wdata -> rdata, 1-cycle read latency).
Decodes each request to either a local byte-writable word RAM or a small memory-mapped register block (LED, NUM, SWITCH, TIMER, SIMU_FLAG).
Sits in the SoC beside the CPU top and drives data_sram_rdata back into the MEM stage.

Parameters:
DEPTH, 65536, RAM size in 32-bit words (power of two)
ADDR_W, 16, log2(DEPTH); word index = addr[ADDR_W+1:2]
CONF_BASE, 32'hBFAF_0000, register block base; match = addr[31:16] == CONF_BASE[31:16]
SIMU_FLAG, 32'hFFFF_FFFF, constant returned by the SIMU_FLAG register

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
data_sram_en  in  1  request valid this cycle
data_sram_wen  in  4  byte write enables, lane i = wdata[8i+7:8i]
data_sram_addr  in  32  byte address; [1:0] ignored
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  read data, valid the cycle after an en=1 request
led  out  16  LED register
num_data  out  32  NUM register (seven-segment value)
switch  in  8  switch inputs, sampled at read

Behaviour:
- One clock, synchronous active-high reset. Reset values: data_sram_rdata=0, led=16'h0000, num_data=0, timer=0. RAM contents are not reset.
- Request accepted every cycle en=1. No stall and no backpressure.
- Read latency is 1: rdata at edge N+1 reflects the request at edge N. When en=0, rdata holds its last value.
- en=1 with wen!=0 performs the write and a read of the same word. Read-first: rdata returns the pre-write value.
- Decode, register block (addr matches CONF_BASE), by offset addr[15:0]:
  - 16'hF000 LED: RW. Lanes 0/1 write led[15:0]; lanes 2/3 ignored. Reads as {16'h0, led}.
  - 16'hF010 NUM: RW. All 4 lanes.
  - 16'hF020 SWITCH: RO, {24'h0, switch}. Writes ignored.
  - 16'hE000 TIMER: RW. Byte-lane merge.
  - 16'hFFF0 SIMU_FLAG: RO, constant.
  - Any other offset reads 0; writes are ignored.
- Decode, otherwise: RAM word addr[ADDR_W+1:2]. Upper bits ignored, so the address aliases modulo DEPTH.
- Byte merge: each enabled lane replaces its byte; disabled lanes keep their old value. wen=0 is a pure read.
- TIMER: increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A write in the same cycle wins: the next value is the merged write value, no increment that cycle.
  - A read returns the value held at the request edge, i.e. before that cycle's increment.
- Reset asserted mid-operation: registers and rdata go to reset values the next edge. A write issued in the reset cycle is dropped for registers; a RAM write in that cycle is also suppressed.
- Register reads are registered through the same output flop as RAM reads. Latency is identical in both paths.

Optional Feature:
DSRAM_TIMER_EN
- Defined: TIMER register present as described.
- Undefined: no counter flops; offset 16'hE000 reads 0 and writes are ignored, same as an unmapped offset.

Decomposition:
- Shared package: CONF_BASE default, offset constants (LED_OFF, NUM_OFF, SWITCH_OFF, TIMER_OFF, SIMU_OFF), byte-merge helper function.
- One sub-module: sram_bank. Single-port, read-first, byte-enable, DEPTH x 32, registered output.
- Register block and output mux stay in data_sram_resp.

Test Plan:
- Write 0x1122_3344 wen=F to 0x0000_0010, then read at 0x0000_0010 -> rdata=0x1122_3344 exactly one cycle after the read request; rdata holds when en=0.
- Write 0xAABB_CCDD wen=0101 over 0x1122_3344 at the same word -> read returns 0x11BB_33DD. A write+read in one cycle returns 0x1122_3344 (old value).
- Write 0x0000_1234 wen=F to 0xBFAF_F000 -> led=16'h1234 next cycle.
  - Read 0xBFAF_F020 with switch=8'h5A -> 0x0000_005A.
  - Read 0xBFAF_FFF0 -> SIMU_FLAG.
  - Read 0xBFAF_F100 -> 0.
- With DSRAM_TIMER_EN: after reset, a read at cycle k returns k-1-relative count. Write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0 (wrap). Without the macro, reads return 0.
- Address alias: with DEPTH=65536, write to 0x0004_0000 -> read at 0x0000_0000 returns the same word.
- Assert reset while led=16'h1234, num=5, timer running -> all read 0 next cycle. A write in the reset cycle leaves the RAM word unchanged.
